// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon-128 encryption control path.
// Round indices, xor_begin mode encodings, controller state and round-counter load selects.
package ascon_pack;

  localparam logic [3:0] ROUND_PA_START = 4'd0;
  localparam logic [3:0] ROUND_PB_START = 4'd6;
  localparam logic [3:0] ROUND_LAST     = 4'd11;
  localparam logic [3:0] ROUND_PA_NEXT  = 4'd1;
  localparam logic [3:0] ROUND_PB_NEXT  = 4'd7;

  localparam logic [1:0] XB_BYPASS   = 2'b00;
  localparam logic [1:0] XB_DATA     = 2'b01;
  localparam logic [1:0] XB_DATA_KEY = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT_AD,
    ST_AD,
    ST_WAIT_PT,
    ST_PT,
    ST_FINAL,
    ST_DONE
  } type_ctrl_state;

  typedef enum logic [1:0] {
    LD_ZERO,
    LD_PA,
    LD_PB
  } type_round_load;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned blk_cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ascon_round_counter.sv
// 4-bit permutation round counter: synchronous load of 0/1/7, increment enable,
// saturates at round 11 so the index never leaves the 0..11 range.
module ascon_round_counter
  import ascon_pack::*;
(
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_load,
  input  type_round_load i_load_sel,
  input  logic           i_en,
  output logic [3:0]     o_round,
  output logic           o_last
);

  logic [3:0] r_round;
  logic [3:0] w_load_val;

  always_comb begin
    w_load_val = ROUND_PA_START;
    case (i_load_sel)
      LD_PA:   w_load_val = ROUND_PA_NEXT;
      LD_PB:   w_load_val = ROUND_PB_NEXT;
      default: w_load_val = ROUND_PA_START;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_round <= ROUND_PA_START;
    end else if (i_load) begin
      r_round <= w_load_val;
    end else if (i_en && (r_round != ROUND_LAST)) begin
      r_round <= r_round + 4'd1;
    end
  end

  assign o_round = r_round;
  assign o_last  = (r_round == ROUND_LAST);

endmodule

// File: rtl/ascon_fsm_ctrl.sv
// Ascon-128 encryption controller: one round per clock, init(pa) -> AD(pb) -> PT(pb) -> final(pa) -> tag.
// Data blocks are taken one at a time over a valid/ready handshake in the WAIT states.
module ascon_fsm_ctrl
  import ascon_pack::*;
#(
  parameter int unsigned AD_BLOCKS = 1,
  parameter int unsigned PT_BLOCKS = 4
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic [3:0] round_o,
  output logic       en_reg_state_o,
  output logic       init_state_o,
  output logic [1:0] mode_xor_begin_o,
  output logic       bypass_xor_end_o,
  output logic       mode_init_data_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       busy_o,
  output logic       end_o
);

  localparam int unsigned BLK_MAX = (AD_BLOCKS > PT_BLOCKS) ? AD_BLOCKS : PT_BLOCKS;
  localparam int unsigned BLK_W   = blk_cnt_width(BLK_MAX);
  localparam logic [BLK_W-1:0] AD_LAST_IDX = BLK_W'(AD_BLOCKS - 1);
  localparam logic [BLK_W-1:0] PT_LAST_IDX = BLK_W'(PT_BLOCKS - 1);

  type_ctrl_state   r_state;
  type_ctrl_state   w_state_nxt;
  logic [BLK_W-1:0] r_blk_cnt;
  logic             w_blk_inc;
  logic             w_blk_clr;
  logic             w_ad_last;
  logic             w_pt_last;
  logic             w_cnt_load;
  type_round_load   w_cnt_sel;
  logic             w_cnt_en;
  logic [3:0]       w_round;
  logic             w_round_last;

  ascon_round_counter u_round_counter (
    .i_clk      (clock_i),
    .i_rst_n    (resetb_i),
    .i_load     (w_cnt_load),
    .i_load_sel (w_cnt_sel),
    .i_en       (w_cnt_en),
    .o_round    (w_round),
    .o_last     (w_round_last)
  );

  assign w_ad_last = (r_blk_cnt == AD_LAST_IDX);
  assign w_pt_last = (r_blk_cnt == PT_LAST_IDX);

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counts AD blocks, then is reused for PT blocks after the AD phase clears it.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_blk_cnt <= '0;
    end else if (w_blk_clr) begin
      r_blk_cnt <= '0;
    end else if (w_blk_inc) begin
      r_blk_cnt <= r_blk_cnt + BLK_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start_i)      w_state_nxt = ST_INIT;
      ST_INIT:          if (w_round_last) w_state_nxt = ST_WAIT_AD;
      ST_WAIT_AD:       if (data_valid_i) w_state_nxt = ST_AD;
      ST_AD:            if (w_round_last) w_state_nxt = w_ad_last ? ST_WAIT_PT : ST_WAIT_AD;
      ST_WAIT_PT:       if (data_valid_i) w_state_nxt = w_pt_last ? ST_FINAL : ST_PT;
      ST_PT:            if (w_round_last) w_state_nxt = ST_WAIT_PT;
      ST_FINAL:         if (w_round_last) w_state_nxt = ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    data_ready_o     = 1'b0;
    round_o          = ROUND_PA_START;
    en_reg_state_o   = 1'b0;
    init_state_o     = 1'b0;
    mode_xor_begin_o = XB_BYPASS;
    bypass_xor_end_o = 1'b1;
    mode_init_data_o = 1'b0;
    en_cipher_o      = 1'b0;
    en_tag_o         = 1'b0;
    busy_o           = 1'b1;
    end_o            = 1'b0;
    w_cnt_load       = 1'b0;
    w_cnt_sel        = LD_ZERO;
    w_cnt_en         = 1'b0;
    w_blk_inc        = 1'b0;
    w_blk_clr        = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        busy_o = 1'b0;
        end_o  = (r_state == ST_DONE);
        if (start_i) begin
          init_state_o   = 1'b1;
          en_reg_state_o = 1'b1;
          w_cnt_load     = 1'b1;
          w_cnt_sel      = LD_PA;
          w_blk_clr      = 1'b1;
        end
      end
      ST_INIT: begin
        round_o        = w_round;
        en_reg_state_o = 1'b1;
        w_cnt_en       = 1'b1;
        if (w_round_last) begin
          bypass_xor_end_o = 1'b0;
          w_cnt_load       = 1'b1;
        end
      end
      ST_WAIT_AD: begin
        data_ready_o = 1'b1;
        round_o      = ROUND_PB_START;
        if (data_valid_i) begin
          en_reg_state_o   = 1'b1;
          mode_xor_begin_o = XB_DATA;
          w_cnt_load       = 1'b1;
          w_cnt_sel        = LD_PB;
        end
      end
      ST_AD: begin
        round_o        = w_round;
        en_reg_state_o = 1'b1;
        w_cnt_en       = 1'b1;
        if (w_round_last) begin
          w_cnt_load = 1'b1;
          w_blk_inc  = !w_ad_last;
          w_blk_clr  = w_ad_last;
          if (w_ad_last) begin
            bypass_xor_end_o = 1'b0;
            mode_init_data_o = 1'b1;
          end
        end
      end
      ST_WAIT_PT: begin
        data_ready_o = 1'b1;
        round_o      = ROUND_PB_START;
        if (data_valid_i) begin
          en_reg_state_o = 1'b1;
          en_cipher_o    = 1'b1;
          w_cnt_load     = 1'b1;
          // The last PT block feeds the key back in and starts finalisation at round 0.
          if (w_pt_last) begin
            round_o          = ROUND_PA_START;
            mode_xor_begin_o = XB_DATA_KEY;
            w_cnt_sel        = LD_PA;
          end else begin
            mode_xor_begin_o = XB_DATA;
            w_cnt_sel        = LD_PB;
          end
        end
      end
      ST_PT: begin
        round_o        = w_round;
        en_reg_state_o = 1'b1;
        w_cnt_en       = 1'b1;
        if (w_round_last) begin
          w_cnt_load = 1'b1;
          w_blk_inc  = 1'b1;
        end
      end
      ST_FINAL: begin
        round_o        = w_round;
        en_reg_state_o = 1'b1;
        w_cnt_en       = 1'b1;
        if (w_round_last) begin
          bypass_xor_end_o = 1'b0;
          en_tag_o         = 1'b1;
          w_cnt_load       = 1'b1;
        end
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

endmodule
